// File: rtl/framebuffer_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_uart_dump
// Purpose  : Streams the framebuffer RAM out over the UART transmitter.
//            Each dump is sent as 0xAA 0x55, then the data bytes, then an
//            8-bit additive checksum of the data bytes.
// Revision : 1.0  initial release
// ============================================================================
module framebuffer_uart_dump #(
    parameter int FB_SIZE     = 9600,
    parameter int ADDR_WIDTH  = 14,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [7:0]            ram_data,
    output logic [7:0]            tx_data,
    output logic                  tx_load,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int                    c_CNT_W     = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(RAM_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(FB_SIZE - 1);
    localparam logic [7:0]            c_SYNC0     = 8'hAA;
    localparam logic [7:0]            c_SYNC1     = 8'h55;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR0 = 3'd1;
    localparam logic [2:0] c_HDR1 = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_SEND = 3'd4;
    localparam logic [2:0] c_SUM  = 3'd5;

    logic [2:0]            r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr;
    logic [7:0]            r_data,  w_data;
    logic                  r_load,  w_load;
    logic                  r_busy,  w_busy;
    logic                  r_done,  w_done;
    logic [7:0]            r_sum,   w_sum;
    logic [c_CNT_W-1:0]    r_cnt,   w_cnt;
    logic                  w_accept;

    assign w_accept = r_load & tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_load  <= w_load;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_sum   <= w_sum;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_data  = r_data;
        w_load  = r_load;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_sum   = r_sum;
        w_cnt   = r_cnt;

        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state = c_HDR0;
                    w_data  = c_SYNC0;
                    w_load  = 1'b1;
                    w_busy  = 1'b1;
                    w_addr  = '0;
                    w_sum   = '0;
                end
            end
            c_HDR0: begin
                if (w_accept) begin
                    w_state = c_HDR1;
                    w_data  = c_SYNC1;
                end
            end
            c_HDR1: begin
                if (w_accept) begin
                    w_state = c_WAIT;
                    w_load  = 1'b0;
                    w_cnt   = '0;
                end
            end
            c_WAIT: begin
                // read_address has been stable since entry, so the RAM output
                // is valid on the RAM_LATENCY-th edge
                if (r_cnt == c_CNT_LAST) begin
                    w_state = c_SEND;
                    w_data  = ram_data;
                    w_load  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            c_SEND: begin
                if (w_accept) begin
                    w_sum = r_sum + r_data;
                    if (r_addr == c_ADDR_LAST) begin
                        w_state = c_SUM;
                        w_data  = r_sum + r_data;
                    end else begin
                        w_state = c_WAIT;
                        w_addr  = r_addr + 1'b1;
                        w_load  = 1'b0;
                        w_cnt   = '0;
                    end
                end
            end
            c_SUM: begin
                if (w_accept) begin
                    w_state = c_IDLE;
                    w_load  = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_addr  = '0;
                end
            end
            default: begin
                w_state = c_IDLE;
                w_load  = 1'b0;
                w_busy  = 1'b0;
                w_addr  = '0;
            end
        endcase
    end

    assign read_address = r_addr;
    assign tx_data      = r_data;
    assign tx_load      = r_load;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: doc/framebuffer_uart_dump.md
# framebuffer_uart_dump

Reads the 9600-byte VGA framebuffer RAM sequentially and streams it out through the UART transmitter, so the host can verify what it wrote over the serial link. It is the readback counterpart of the UART-receive-to-RAM write path. It uses a second read port of the framebuffer RAM and drives the UART `txDataIN`/`txLoadIN` pair. Each dump is framed with a two-byte sync header and a trailing 8-bit checksum.

## Interface
Parameters:
- `FB_SIZE`, default 9600: number of data bytes per dump, read from addresses 0..FB_SIZE-1.
- `ADDR_WIDTH`, default 14: RAM address width.
- `RAM_LATENCY`, default 2: number of clk edges from a `read_address` change to the edge at which `ram_data` is valid for sampling. Must be ≥1.

Ports:
- `clk` in 1: single clock, 50 MHz system clock.
- `reset` in 1: asynchronous, active-high. Forces all state and outputs to their reset values immediately.
- `start` in 1: request a dump. Sampled only while in IDLE.
- `read_address` out ADDR_WIDTH: framebuffer read address.
- `ram_data` in 8: framebuffer read data.
- `tx_data` out 8: byte presented to the UART.
- `tx_load` out 1: `tx_data` valid.
- `tx_ready` in 1: UART can accept a byte.
- `busy` out 1: dump in progress.
- `done` out 1: one-cycle pulse when a dump completes.

## Operation
- Byte stream per dump: 0xAA, 0x55, then ram[0]..ram[FB_SIZE-1], then the checksum. The checksum is the sum of all data bytes mod 256; header bytes are excluded. Total stream length is FB_SIZE+3 bytes.
- Transfer rule: a byte is accepted on a rising edge where `tx_load` and `tx_ready` are both 1.
  - While `tx_load` is 1 and the byte is not yet accepted, `tx_data` must not change.
  - `tx_load` never drops before acceptance.
- State machine: IDLE, HDR0, HDR1, WAIT, SEND, SUM.
  - IDLE → HDR0 on an edge with `start`=1. On that edge: `tx_data`=0xAA, `tx_load`=1, `busy`=1, `read_address`=0, checksum=0.
  - HDR0 → HDR1 on acceptance. `tx_data`=0x55, `tx_load` stays 1.
  - HDR1 → WAIT on acceptance. `tx_load`=0, wait counter cleared.
  - WAIT: count edges. On the RAM_LATENCY-th edge after entering WAIT, capture `ram_data` into `tx_data`, set `tx_load`=1, go to SEND.
  - SEND, on acceptance:
    - Add `tx_data` to the checksum.
    - If `read_address`=FB_SIZE-1: go to SUM with `tx_data` = checksum + current byte (mod 256) and `tx_load`=1.
    - Otherwise: `read_address`+1, `tx_load`=0, go to WAIT.
  - SUM → IDLE on acceptance. `tx_load`=0, `busy`=0, `done`=1 for exactly one cycle, `read_address`=0.
- `start` is ignored in every state except IDLE. A `start` on the cycle `done` is high is accepted, because the state is IDLE by then.
- `read_address` never exceeds FB_SIZE-1. It returns to 0 at completion and does not wrap mid-dump.
- The checksum accumulator is 8 bits with natural mod-256 wrap.

## Timing
- Reset values: `tx_load`=0, `tx_data`=0x00, `read_address`=0, `busy`=0, `done`=0. State is IDLE, checksum is 0.
- `tx_load` rises on the first edge after `start` is sampled.
- With `tx_ready` held at 1:
  - Header bytes are accepted on consecutive edges.
  - The first data byte's `tx_load` rises RAM_LATENCY edges after HDR1 acceptance.
  - Consecutive data bytes are accepted every RAM_LATENCY+1 cycles (3 at the default).
  - The checksum is accepted on the edge after the last data byte.
- `done` is asserted on the edge the checksum is accepted and cleared on the next edge.
- Backpressure can stall any state holding `tx_load`=1 indefinitely. WAIT is not affected by `tx_ready`.
- Reset asserted mid-dump aborts immediately: outputs go to reset values asynchronously and no `done` is issued. The next `start` begins again with 0xAA.

## Test plan
- Reset: assert `reset` with arbitrary inputs → `tx_load`=0, `tx_data`=0, `read_address`=0, `busy`=0, `done`=0.
- FB_SIZE=4, RAM = 01 02 03 04, `tx_ready`=1, pulse `start`:
  - Accepted bytes are AA 55 01 02 03 04 0A.
  - Data bytes are accepted 3 cycles apart.
  - `done` pulses once, `busy` falls with it.
- Same configuration with pseudo-random `tx_ready`:
  - Identical byte sequence.
  - `tx_data` stable whenever `tx_load`=1 and the byte is unaccepted.
  - `tx_load` never falls before acceptance.
- `start` pulsed during a dump is ignored: exactly 7 bytes, one `done`. A `start` on the `done` cycle begins a second dump with AA.
- `reset` asserted after the third data byte → outputs zero immediately, no `done`. A new `start` yields the full AA 55 01 02 03 04 0A.
- Default FB_SIZE=9600, ram[i]=i mod 256, `tx_ready`=1:
  - 9603 bytes.
  - Last data byte is 0x7F at address 9599.
  - Checksum is 0x40.
  - `read_address` is 0 after `done`.
